nn_param_loader: RTL and testbench
==================================

Name: nn_param_loader

Overview:
- Master side of the neuron parameter-load interface. Pulls a packed parameter stream of 32-bit words from DMA/FIFO over a valid/ready handshake.
- Drives weight_value/weight_valid, bias_value/bias_valid and config_layer_num/config_neuron_num onto the shared broadcast bus of one layer's neurons.
- Per neuron, emits exactly the commanded number of weights followed by one bias, then advances to the next neuron.
- Sits between the PS-side DMA and every neuron of the network.

Parameters:
- NEURON_CNT_W, 10, width of cmd_num_neurons and the neuron counter.
- WEIGHT_CNT_W, 10, width of cmd_num_weights and the weight counter (covers 784).
- WORD_W, 32, stream and parameter word width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- start  in  1  single-cycle load request; honoured only in IDLE
- cmd_layer  in  32  target layer number; latched on start
- cmd_num_neurons  in  NEURON_CNT_W  neurons to load; latched on start
- cmd_num_weights  in  WEIGHT_CNT_W  weights per neuron; latched on start
- s_data  in  WORD_W  parameter stream word
- s_valid  in  1  stream word valid
- s_ready  out  1  loader accepts word
- weight_value  out  32  weight word to neurons
- weight_valid  out  1  weight strobe
- bias_value  out  32  bias word to neurons
- bias_valid  out  1  bias strobe
- config_layer_num  out  32  target layer
- config_neuron_num  out  32  target neuron index (zero-extended counter)
- busy  out  1  high outside IDLE
- done  out  1  single-cycle completion pulse

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. Reset forces:
  - state IDLE;
  - s_ready, weight_valid, bias_valid, busy, done = 0;
  - weight_value, bias_value, config_layer_num, config_neuron_num = 0;
  - all counters = 0.
- Reset mid-load aborts immediately. Neurons are not rewound; software must reset the whole network.
- FSM states: IDLE, WEIGHT, BIAS, NEXT, DONE.
- IDLE:
  - start latches cmd_*, sets config_layer_num = cmd_layer, config_neuron_num = 0, wcnt = 0, ncnt = 0.
  - Next state is WEIGHT, or BIAS if cmd_num_weights == 0, or DONE if cmd_num_neurons == 0.
- s_ready is a combinational function of state: 1 only in WEIGHT and BIAS. A transfer occurs on s_valid & s_ready.
- WEIGHT:
  - On each transfer, register weight_value <= s_data and assert weight_valid for exactly the following cycle (latency 1). wcnt increments.
  - The transfer with wcnt == num_weights-1 moves to BIAS.
  - No transfer means weight_valid = 0 the next cycle; stalls of any length are allowed.
- BIAS:
  - On a transfer, bias_value <= s_data, bias_valid pulses the next cycle, state goes to NEXT.
- NEXT (one cycle, s_ready = 0):
  - The last weight_valid/bias_valid of a neuron always coincides with the old config_neuron_num. The index never changes in the cycle a strobe is high.
  - If ncnt == num_neurons-1, go to DONE.
  - Otherwise increment ncnt and config_neuron_num, clear wcnt, and go to WEIGHT (or BIAS if num_weights == 0).
- DONE: done = 1 for one cycle, then IDLE. busy falls in the same cycle done rises.
- weight_valid and bias_valid are never high together.
- config_layer_num and config_neuron_num hold their last values in IDLE.
- start while busy is ignored. start in the DONE cycle is ignored.
- Words presented on s_data while s_ready = 0 are not consumed.
- Throughput: 1 word/cycle in WEIGHT/BIAS. Per-neuron overhead is 1 cycle (NEXT).

Decomposition:
- Shared package nn_cfg_pkg holds:
  - the state enum (IDLE/WEIGHT/BIAS/NEXT/DONE);
  - WORD_W, the default counter widths and the broadcast-bus word widths, which neurons also use.
- No sub-module. Counters and FSM live in one module.

Test Plan:
- Basic load: start with layer = 1, neurons = 2, weights = 3, stream 0x11,0x22,0x33,0xB0,0x44,0x55,0x66,0xB1 with s_valid held high.
  - weight_valid pulses 0x11..0x33 with neuron_num 0.
  - bias_valid 0xB0 with neuron_num 0.
  - One gap cycle, then the same pattern for neuron 1 with 0x44..0x66, 0xB1.
  - done pulses exactly once; 8 words are consumed.
- Backpressure: same command with s_valid toggling 1,0,0,1 per cycle.
  - Identical output sequence; no duplicate or dropped strobes; weight_valid low on non-transfer cycles.
- Zero cases:
  - neurons = 0: done 2 cycles after start, s_ready never high.
  - weights = 0, neurons = 2: only two bias_valid pulses (neuron 0, then 1).
- start while busy: assert start with layer = 5 mid-load of layer 1. config_layer_num stays 1 and the original load completes unchanged.
- Async reset after the 2nd weight: all outputs are 0 immediately, with no clock edge. After release, a new start with layer = 2, neurons = 1, weights = 4 loads correctly from neuron 0.
- Full size: layer = 0, neurons = 30, weights = 784, incrementing data.
  - Scoreboard 23520 weight strobes and 30 bias strobes.
  - Each strobe matches (neuron, index, value).

Source files
------------

// File: rtl/nn_cfg_pkg.sv
// Shared configuration for the neuron parameter-load path: load FSM states and
// the word widths of the broadcast bus that the loader and every neuron agree on.
package nn_cfg_pkg;

  localparam int PARAM_WORD_W     = 32;
  localparam int DEF_NEURON_CNT_W = 10;
  localparam int DEF_WEIGHT_CNT_W = 10;
  localparam int LAYER_NUM_W      = 32;
  localparam int NEURON_NUM_W     = 32;

  typedef enum logic [2:0] {
    IDLE,
    WEIGHT,
    BIAS,
    NEXT,
    DONE
  } load_state_e;

endpackage

// File: rtl/nn_param_loader.sv
// Streams packed weights and biases from the DMA word stream onto one layer's
// neuron broadcast bus: per neuron, num_weights weight strobes and then one bias strobe.
module nn_param_loader
  import nn_cfg_pkg::*;
#(
  parameter int NEURON_CNT_W = DEF_NEURON_CNT_W,
  parameter int WEIGHT_CNT_W = DEF_WEIGHT_CNT_W,
  parameter int WORD_W       = PARAM_WORD_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [LAYER_NUM_W-1:0]  cmd_layer,
  input  logic [NEURON_CNT_W-1:0] cmd_num_neurons,
  input  logic [WEIGHT_CNT_W-1:0] cmd_num_weights,
  input  logic [WORD_W-1:0]       s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [WORD_W-1:0]       weight_value,
  output logic                    weight_valid,
  output logic [WORD_W-1:0]       bias_value,
  output logic                    bias_valid,
  output logic [LAYER_NUM_W-1:0]  config_layer_num,
  output logic [NEURON_NUM_W-1:0] config_neuron_num,
  output logic                    busy,
  output logic                    done
);

  localparam logic [NEURON_CNT_W-1:0] N_ONE = NEURON_CNT_W'(1);
  localparam logic [WEIGHT_CNT_W-1:0] W_ONE = WEIGHT_CNT_W'(1);

  load_state_e             state_q, state_d;
  logic [NEURON_CNT_W-1:0] num_neurons_q, num_neurons_d;
  logic [NEURON_CNT_W-1:0] ncnt_q, ncnt_d;
  logic [WEIGHT_CNT_W-1:0] num_weights_q, num_weights_d;
  logic [WEIGHT_CNT_W-1:0] wcnt_q, wcnt_d;
  logic [WORD_W-1:0]       weight_value_q, weight_value_d;
  logic [WORD_W-1:0]       bias_value_q, bias_value_d;
  logic [LAYER_NUM_W-1:0]  layer_q, layer_d;
  logic                    weight_valid_q, weight_valid_d;
  logic                    bias_valid_q, bias_valid_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    xfer;

  assign s_ready = (state_q == WEIGHT) || (state_q == BIAS);
  assign xfer    = s_valid && s_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      num_neurons_q  <= '0;
      ncnt_q         <= '0;
      num_weights_q  <= '0;
      wcnt_q         <= '0;
      weight_value_q <= '0;
      bias_value_q   <= '0;
      layer_q        <= '0;
      weight_valid_q <= 1'b0;
      bias_valid_q   <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      num_neurons_q  <= num_neurons_d;
      ncnt_q         <= ncnt_d;
      num_weights_q  <= num_weights_d;
      wcnt_q         <= wcnt_d;
      weight_value_q <= weight_value_d;
      bias_value_q   <= bias_value_d;
      layer_q        <= layer_d;
      weight_valid_q <= weight_valid_d;
      bias_valid_q   <= bias_valid_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  // The neuron index only moves on leaving NEXT, so the final bias strobe of a
  // neuron (visible during NEXT) is still tagged with that neuron's index.
  always_comb begin
    state_d        = state_q;
    num_neurons_d  = num_neurons_q;
    ncnt_d         = ncnt_q;
    num_weights_d  = num_weights_q;
    wcnt_d         = wcnt_q;
    weight_value_d = weight_value_q;
    bias_value_d   = bias_value_q;
    layer_d        = layer_q;
    weight_valid_d = 1'b0;
    bias_valid_d   = 1'b0;
    busy_d         = busy_q;
    done_d         = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          num_neurons_d = cmd_num_neurons;
          num_weights_d = cmd_num_weights;
          layer_d       = cmd_layer;
          ncnt_d        = '0;
          wcnt_d        = '0;
          busy_d        = 1'b1;
          if (cmd_num_neurons == '0) begin
            state_d = DONE;
          end else if (cmd_num_weights == '0) begin
            state_d = BIAS;
          end else begin
            state_d = WEIGHT;
          end
        end
      end
      WEIGHT: begin
        if (xfer) begin
          weight_value_d = s_data;
          weight_valid_d = 1'b1;
          wcnt_d         = wcnt_q + W_ONE;
          if (wcnt_q == num_weights_q - W_ONE) begin
            state_d = BIAS;
          end
        end
      end
      BIAS: begin
        if (xfer) begin
          bias_value_d = s_data;
          bias_valid_d = 1'b1;
          state_d      = NEXT;
        end
      end
      NEXT: begin
        if (ncnt_q == num_neurons_q - N_ONE) begin
          state_d = DONE;
        end else begin
          ncnt_d  = ncnt_q + N_ONE;
          wcnt_d  = '0;
          state_d = (num_weights_q == '0) ? BIAS : WEIGHT;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign weight_value      = weight_value_q;
  assign weight_valid      = weight_valid_q;
  assign bias_value        = bias_value_q;
  assign bias_valid        = bias_valid_q;
  assign config_layer_num  = layer_q;
  assign config_neuron_num = {{(NEURON_NUM_W-NEURON_CNT_W){1'b0}}, ncnt_q};
  assign busy              = busy_q;
  assign done              = done_q;

endmodule

// File: tb/tb_nn_param_loader.sv
// Randomized bench for nn_param_loader: each load builds the expected strobe list
// straight from the command and stream words, then checks strobes, timing and completion.
module tb_nn_param_loader;
  import nn_cfg_pkg::*;

  localparam int NW = 10;
  localparam int WW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   cmd_layer = '0;
  logic [NW-1:0] cmd_num_neurons = '0;
  logic [WW-1:0] cmd_num_weights = '0;
  logic [31:0]   s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [31:0]   weight_value;
  logic          weight_valid;
  logic [31:0]   bias_value;
  logic          bias_valid;
  logic [31:0]   config_layer_num;
  logic [31:0]   config_neuron_num;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  logic [31:0] basic_words [8] = '{32'h11, 32'h22, 32'h33, 32'hB0,
                                   32'h44, 32'h55, 32'h66, 32'hB1};

  typedef struct {
    bit          is_bias;
    int          neuron;
    logic [31:0] value;
  } strobe_t;

  nn_param_loader #(
    .NEURON_CNT_W (NW),
    .WEIGHT_CNT_W (WW),
    .WORD_W       (32)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .cmd_layer         (cmd_layer),
    .cmd_num_neurons   (cmd_num_neurons),
    .cmd_num_weights   (cmd_num_weights),
    .s_data            (s_data),
    .s_valid           (s_valid),
    .s_ready           (s_ready),
    .weight_value      (weight_value),
    .weight_valid      (weight_valid),
    .bias_value        (bias_value),
    .bias_valid        (bias_valid),
    .config_layer_num  (config_layer_num),
    .config_neuron_num (config_neuron_num),
    .busy              (busy),
    .done              (done)
  );

  always #5 clk = ~clk;

  // data_mode: 0 random words, 1 incrementing words, 2 the fixed basic pattern.
  // valid_mode: 0 always valid, 1 pattern 1,0,0,1, 2 random.
  task automatic run_load(input string name, input logic [31:0] layer, input int n,
                          input int w, input int valid_mode, input int data_mode,
                          input int busy_iter, input bit start_in_done, input int abort_w);
    strobe_t     exp_q[$];
    strobe_t     e;
    logic [31:0] words[$];
    logic [31:0] v;
    logic [31:0] got_val;
    int          total = n * (w + 1);
    int          exp_done = n * (w + 2) + 2;
    int          budget = 4 * total + 60;
    int          consumed = 0;
    int          done_cnt = 0;
    int          done_iter = -1;
    int          w_seen = 0;
    int          k = 0;
    bit          last_xfer = 1'b0;
    bit          xfer;
    bit          ready_seen = 1'b0;
    bit          aborted = 1'b0;
    bit          pat;
    bit          exp_busy;

    for (int ni = 0; ni < n; ni++) begin
      for (int wi = 0; wi <= w; wi++) begin
        if (data_mode == 1) v = 32'(k);
        else if (data_mode == 2 && k < 8) v = basic_words[k];
        else v = $urandom();
        k++;
        words.push_back(v);
        e.is_bias = (wi == w);
        e.neuron  = ni;
        e.value   = v;
        exp_q.push_back(e);
      end
    end
    words.push_back($urandom());
    words.push_back($urandom());

    @(posedge clk); #1;
    cmd_layer       = layer;
    cmd_num_neurons = NW'(n);
    cmd_num_weights = WW'(w);
    start           = 1'b1;

    for (int it = 0; it < budget; it++) begin
      if (it > 0) begin
        start = 1'b0;
        if (it == busy_iter) begin
          start = 1'b1; cmd_layer = 32'd5; cmd_num_neurons = NW'(3); cmd_num_weights = WW'(1);
        end
        if (start_in_done && it == exp_done - 1) begin
          start = 1'b1; cmd_layer = 32'd9; cmd_num_neurons = NW'(1); cmd_num_weights = WW'(1);
        end
      end
      case (valid_mode)
        0: pat = 1'b1;
        1: pat = (it % 4 == 0) || (it % 4 == 3);
        default: pat = 1'($urandom_range(0, 1));
      endcase
      s_valid = pat && (words.size() > 0);
      s_data  = (words.size() > 0) ? words[0] : $urandom();

      @(negedge clk);
      if (s_ready) ready_seen = 1'b1;

      checks++;
      if (weight_valid && bias_valid) begin
        errors++;
        $display("[TB] FAIL %s both_strobes it=%0d: got weight_valid=1 bias_valid=1, expected at most one", name, it);
      end
      checks++;
      if ((weight_valid || bias_valid) !== last_xfer) begin
        errors++;
        $display("[TB] FAIL %s strobe_timing it=%0d: got strobe=%0b, expected %0b", name, it,
                 weight_valid || bias_valid, last_xfer);
      end
      if (weight_valid || bias_valid) begin
        if (weight_valid) w_seen++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL %s extra_strobe it=%0d: got a strobe, expected none", name, it);
        end else begin
          e = exp_q.pop_front();
          got_val = bias_valid ? bias_value : weight_value;
          if ({bias_valid, config_neuron_num, got_val, config_layer_num} !==
              {e.is_bias, 32'(e.neuron), e.value, layer}) begin
            errors++;
            $display("[TB] FAIL %s strobe it=%0d: got bias=%0b neuron=%0d value=%h layer=%0d, expected bias=%0b neuron=%0d value=%h layer=%0d",
                     name, it, bias_valid, config_neuron_num, got_val, config_layer_num,
                     e.is_bias, e.neuron, e.value, layer);
          end
        end
      end

      if (done === 1'b1) begin
        done_cnt++;
        if (done_iter < 0) done_iter = it;
      end
      exp_busy = (it >= 1) && (done_iter < 0);
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("[TB] FAIL %s busy it=%0d: got %0b, expected %0b", name, it, busy, exp_busy);
      end

      if (abort_w >= 0 && w_seen == abort_w) begin
        rst_n = 1'b0;
        #1;
        checks++;
        if ({s_ready, weight_valid, bias_valid, busy, done, weight_value, bias_value,
             config_layer_num, config_neuron_num} !== '0) begin
          errors++;
          $display("[TB] FAIL %s async_reset: got rdy=%0b wv=%0b bv=%0b busy=%0b done=%0b w=%h b=%h layer=%h neuron=%h, expected all zero",
                   name, s_ready, weight_valid, bias_valid, busy, done, weight_value, bias_value,
                   config_layer_num, config_neuron_num);
        end
        aborted = 1'b1;
        break;
      end

      xfer = s_valid && s_ready;
      @(posedge clk); #1;
      if (xfer) begin
        void'(words.pop_front());
        consumed++;
      end
      last_xfer = xfer;
      if (done_iter >= 0 && it >= done_iter + 4) break;
    end

    start   = 1'b0;
    s_valid = 1'b0;
    if (!aborted) begin
      checks++;
      if (done_iter < 0) begin
        errors++;
        $display("[TB] FAIL %s timeout: got no done within %0d cycles, expected done", name, budget);
      end
      checks++;
      if (done_cnt != 1) begin
        errors++;
        $display("[TB] FAIL %s done_count: got %0d, expected 1", name, done_cnt);
      end
      checks++;
      if (consumed != total) begin
        errors++;
        $display("[TB] FAIL %s consumed: got %0d, expected %0d", name, consumed, total);
      end
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("[TB] FAIL %s missing_strobes: got %0d left, expected 0", name, exp_q.size());
      end
      if (valid_mode == 0) begin
        checks++;
        if (done_iter != exp_done) begin
          errors++;
          $display("[TB] FAIL %s done_latency: got cycle %0d, expected %0d", name, done_iter, exp_done);
        end
      end
      if (n == 0) begin
        checks++;
        if (ready_seen) begin
          errors++;
          $display("[TB] FAIL %s ready_zero: got s_ready high, expected never", name);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s_valid = 1'b1;
    s_data = 32'hDEAD_BEEF;
    #12;
    checks++;
    if ({s_ready, weight_valid, bias_valid, busy, done, weight_value, bias_value,
         config_layer_num, config_neuron_num} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_state: got rdy=%0b wv=%0b bv=%0b busy=%0b done=%0b, expected all zero",
               s_ready, weight_valid, bias_valid, busy, done);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({s_ready, weight_valid, busy, done} !== 4'b0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: got rdy=%0b wv=%0b busy=%0b done=%0b, expected 0",
               s_ready, weight_valid, busy, done);
    end
    s_valid = 1'b0;
  endtask

  task automatic test_basic();
    run_load("basic", 32'd1, 2, 3, 0, 2, -1, 1'b1, -1);
  endtask

  task automatic test_backpressure();
    run_load("backpressure", 32'd1, 2, 3, 1, 2, -1, 1'b0, -1);
  endtask

  task automatic test_zero_cases();
    run_load("zero_neurons", 32'd7, 0, 5, 0, 0, -1, 1'b0, -1);
    run_load("zero_weights", 32'd3, 2, 0, 0, 0, -1, 1'b0, -1);
  endtask

  task automatic test_start_while_busy();
    run_load("start_busy", 32'd1, 2, 3, 0, 0, 3, 1'b0, -1);
  endtask

  task automatic test_async_reset();
    run_load("reset_abort", 32'd1, 2, 3, 0, 0, -1, 1'b0, 2);
    @(posedge clk); #2;
    rst_n = 1'b1;
    run_load("after_reset", 32'd2, 1, 4, 0, 0, -1, 1'b0, -1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      run_load("random", $urandom(), int'($urandom_range(1, 4)), int'($urandom_range(0, 6)),
               2, 0, -1, 1'b0, -1);
    end
  endtask

  task automatic test_full_size();
    run_load("full_size", 32'd0, 30, 784, 0, 1, -1, 1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_cases();
    test_start_while_busy();
    test_async_reset();
    test_random();
    test_full_size();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
